// File: rtl/rgb_fade_ctrl_if.sv
// Fade command channel: valid/ready handshake carrying channel select,
// target level and per-step increment.
interface rgb_fade_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_chan;
  logic [7:0] cmd_target;
  logic [7:0] cmd_step;

  modport master (output cmd_valid, cmd_chan, cmd_target, cmd_step, input cmd_ready);
  modport slave  (input cmd_valid, cmd_chan, cmd_target, cmd_step, output cmd_ready);
endinterface

// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl: three-channel level ramp controller feeding the R/G/B pwm
// blocks. Ramp steps land only on the 256-clock frame boundary so a duty
// change never splits a PWM period.
// Optional feature macro: RGB_FADE_HOLD_EN adds a 'hold' input that freezes
// all ramps (strobes ignored) while commands and snaps still apply.

// One channel: level/target/step registers plus an IDLE/RAMP FSM.
module rgb_fade_ch (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic [7:0] cmd_target,
  input  logic [7:0] cmd_step,
  input  logic       strobe,
  output logic [7:0] level,
  output logic       busy,
  output logic       done
);
  typedef enum logic {IDLE, RAMP} ch_state_e;

  ch_state_e  state, state_n;
  logic [7:0] target, target_n, step, step_n, level_n, ramp_lvl;
  logic       done_n;
  logic [8:0] up_sum, dn_diff;

  // state and datapath registers; done is registered so it aligns with level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      level  <= '0;
      target <= '0;
      step   <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      level  <= level_n;
      target <= target_n;
      step   <= step_n;
      done   <= done_n;
    end
  end

  // next state: a command always beats a strobe on this channel
  always_comb begin
    state_n  = state;
    level_n  = level;
    target_n = target;
    step_n   = step;
    done_n   = 1'b0;
    // 9-bit arithmetic so a large step clamps instead of wrapping
    up_sum   = {1'b0, level} + {1'b0, step};
    dn_diff  = {1'b0, level} - {1'b0, step};
    if (target > level)
      ramp_lvl = (up_sum > {1'b0, target}) ? target : up_sum[7:0];
    else
      ramp_lvl = (dn_diff[8] || (dn_diff[7:0] < target)) ? target : dn_diff[7:0];

    if (sel) begin
      target_n = cmd_target;
      step_n   = cmd_step;
      if (cmd_step == 8'd0 || cmd_target == level) begin
        level_n = cmd_target;
        state_n = IDLE;
        done_n  = 1'b1;
      end else begin
        state_n = RAMP;
      end
    end else if (state == RAMP && strobe) begin
      level_n = ramp_lvl;
      if (ramp_lvl == target) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end
  end

  assign busy = (state == RAMP);
endmodule

module rgb_fade_ctrl #(
  parameter int FRAME_DIV = 1
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef RGB_FADE_HOLD_EN
  input  logic                 hold,
`endif
  rgb_fade_ctrl_if.slave       cmd,
  output logic [23:0]          level_out,
  output logic [2:0]           busy,
  output logic [2:0]           done,
  output logic                 frame_tick
);
  localparam int         NUM_CH   = 3;
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  logic [7:0]              cnt, pre;
  logic                    rdy, accept, strobe, strobe_raw;
  logic [NUM_CH-1:0]       sel;
  logic [NUM_CH-1:0][7:0]  lvl;

  // frame counter, phase-aligned with pwm.count out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt + 8'd1;
  end

  assign frame_tick = (cnt == 8'hFF);

  // prescaler counts frames; strobe on the tick closing the last frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          pre <= '0;
    else if (frame_tick) pre <= (pre == DIV_LAST) ? 8'd0 : pre + 8'd1;
  end

  assign strobe_raw = frame_tick && (pre == DIV_LAST);
`ifdef RGB_FADE_HOLD_EN
  assign strobe = strobe_raw && !hold;
`else
  assign strobe = strobe_raw;
`endif

  // no backpressure: ready rises one edge after reset release and stays up
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdy <= 1'b0;
    else        rdy <= 1'b1;
  end

  assign cmd.cmd_ready = rdy;
  assign accept        = cmd.cmd_valid && rdy;

  // channel decode; chan 3 broadcasts to all
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      sel[i] = accept && (cmd.cmd_chan == 2'(i) || cmd.cmd_chan == 2'd3);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rgb_fade_ch u_ch (
      .clk        (clk),
      .reset      (reset),
      .sel        (sel[g]),
      .cmd_target (cmd.cmd_target),
      .cmd_step   (cmd.cmd_step),
      .strobe     (strobe),
      .level      (lvl[g]),
      .busy       (busy[g]),
      .done       (done[g])
    );
  end

  assign level_out = lvl;
endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Directed bench for rgb_fade_ctrl (FRAME_DIV=1). Inputs driven and outputs
// sampled on the falling edge.
module tb_rgb_fade_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] level_out;
  logic [2:0]  busy, done;
  logic        frame_tick;
  int          n_tests = 0;
  int          n_fail  = 0;
`ifdef RGB_FADE_HOLD_EN
  logic        hold = 1'b0;
`endif

  rgb_fade_ctrl_if bus ();

  rgb_fade_ctrl #(.FRAME_DIV(1)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef RGB_FADE_HOLD_EN
    .hold       (hold),
`endif
    .cmd        (bus.slave),
    .level_out  (level_out),
    .busy       (busy),
    .done       (done),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to the negedge where frame_tick is high (counter == 255)
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 300);
    chk("tick_timeout", 32'(frame_tick), 32'd1);
  endtask

  // through one strobe edge, landing on the negedge after the update
  task automatic step_once();
    wait_tick();
    @(negedge clk);
  endtask

  // one-cycle command issued from a negedge; returns one negedge later
  task automatic send(input logic [1:0] ch, input logic [7:0] tgt, input logic [7:0] stp);
    bus.cmd_valid  = 1'b1;
    bus.cmd_chan   = ch;
    bus.cmd_target = tgt;
    bus.cmd_step   = stp;
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
  endtask

  initial begin
    int c;
    reset          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_chan   = 2'd0;
    bus.cmd_target = 8'd0;
    bus.cmd_step   = 8'd0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_level", 32'(level_out), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'h0);
    chk("rst_tick",  32'(frame_tick), 32'h0);

    reset = 1'b1;
    chk("ready_before_edge", 32'(bus.cmd_ready), 32'h0);
    @(negedge clk);
    chk("ready_after_edge", 32'(bus.cmd_ready), 32'h1);
    c = 1;
    while (!frame_tick && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("first_tick_cycle", 32'(c), 32'd255);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!frame_tick && c < 300);
    chk("tick_period", 32'(c), 32'd256);
    @(negedge clk);
    chk("tick_one_wide", 32'(frame_tick), 32'h0);

    // R up-ramp 0 -> 0x40 by 0x10
    send(2'd0, 8'h40, 8'h10);
    chk("r_busy_set", 32'(busy), 32'h1);
    chk("r_lvl_hold", 32'(level_out), 32'h0);
    step_once();
    chk("r_step1", 32'(level_out), 32'h000010);
    chk("r_step1_done", 32'(done), 32'h0);
    step_once();
    chk("r_step2", 32'(level_out), 32'h000020);
    step_once();
    chk("r_step3", 32'(level_out), 32'h000030);
    chk("r_step3_busy", 32'(busy), 32'h1);
    step_once();
    chk("r_step4", 32'(level_out), 32'h000040);
    chk("r_step4_done", 32'(done), 32'h1);
    chk("r_step4_busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("r_done_width", 32'(done), 32'h0);

    // G snap to 0x30, then down-ramp to 0x05 by 0x10 with clamp
    send(2'd1, 8'h30, 8'h00);
    chk("g_snap_lvl", 32'(level_out), 32'h003040);
    chk("g_snap_done", 32'(done), 32'h2);
    send(2'd1, 8'h05, 8'h10);
    chk("g_snap_done_width", 32'(done), 32'h0);
    step_once();
    chk("g_dn1", 32'(level_out), 32'h002040);
    step_once();
    chk("g_dn2", 32'(level_out), 32'h001040);
    step_once();
    chk("g_dn_clamp", 32'(level_out), 32'h000540);
    chk("g_dn_done", 32'(done), 32'h2);

    // B 0xF0 -> 0xFF by 0x20: clamps at target without wrapping
    send(2'd2, 8'hF0, 8'h00);
    chk("b_snap", 32'(level_out), 32'hF00540);
    step_once();
    send(2'd2, 8'hFF, 8'h20);
    step_once();
    chk("b_up_clamp", 32'(level_out), 32'hFF0540);
    chk("b_up_done", 32'(done), 32'h4);

    // broadcast snap
    send(2'd3, 8'h80, 8'h00);
    chk("bc_lvl", 32'(level_out), 32'h808080);
    chk("bc_done", 32'(done), 32'h7);
    @(negedge clk);
    chk("bc_done_width", 32'(done), 32'h0);

    // collision: R command in the counter==255 cycle skips its step; G steps
    send(2'd0, 8'hC0, 8'h10);
    send(2'd1, 8'h40, 8'h20);
    chk("col_busy", 32'(busy), 32'h3);
    step_once();
    chk("col_pre", 32'(level_out), 32'h806090);
    wait_tick();
    send(2'd0, 8'hA0, 8'h08);
    chk("col_lvl", 32'(level_out), 32'h804090);
    chk("col_done", 32'(done), 32'h2);
    chk("col_busy2", 32'(busy), 32'h1);
    step_once();
    chk("col_r1", 32'(level_out), 32'h804098);
    step_once();
    chk("col_r2", 32'(level_out), 32'h8040A0);
    chk("col_r2_done", 32'(done), 32'h1);

    // retarget mid-ramp: old target 0x20 would be hit next, but no done for it
    send(2'd0, 8'h20, 8'h40);
    step_once();
    chk("rt_pre", 32'(level_out), 32'h804060);
    send(2'd0, 8'h40, 8'h10);
    step_once();
    chk("rt_1", 32'(level_out), 32'h804050);
    chk("rt_1_done", 32'(done), 32'h0);
    chk("rt_1_busy", 32'(busy), 32'h1);
    step_once();
    chk("rt_2", 32'(level_out), 32'h804040);
    chk("rt_2_done", 32'(done), 32'h1);

`ifdef RGB_FADE_HOLD_EN
    // hold freezes B for 3 strobes, then resumes
    send(2'd2, 8'hB0, 8'h10);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_once();
      chk("hold_lvl", 32'(level_out), 32'h804040);
      chk("hold_busy", 32'(busy), 32'h4);
    end
    hold = 1'b0;
    step_once();
    chk("hold_resume", 32'(level_out), 32'h904040);
    send(2'd2, 8'h80, 8'h00);
    chk("hold_snap", 32'(level_out), 32'h804040);
    chk("hold_snap_done", 32'(done), 32'h4);
`endif

    // reset asserted mid-ramp, away from any clock edge
    send(2'd2, 8'h00, 8'h01);
    step_once();
    chk("mr_pre", 32'(level_out), 32'h7F4040);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mr_level", 32'(level_out), 32'h0);
    chk("mr_busy",  32'(busy), 32'h0);
    chk("mr_ready", 32'(bus.cmd_ready), 32'h0);
    chk("mr_tick",  32'(frame_tick), 32'h0);
    #20;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rgb_fade_ctrl.md
# rgb_fade_ctrl

Three-channel fade controller that sequences the 8-bit `level` inputs of the red, green and blue `pwm` instances in the RGB mixer. It accepts fade commands through a valid/ready handshake and ramps each channel from its current level toward a target. Ramp steps are applied only on PWM period boundaries, every 256 clocks, so a duty-cycle change never lands mid-period. It sits between the user/control logic and the three `pwm` blocks.

## Interface
- `FRAME_DIV`, default 1: number of 256-clock PWM frames per ramp step; legal range 1..255.
- `clk`  in  1  system clock, shared with the `pwm` instances.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_chan`  in  2  channel select: 0 = R, 1 = G, 2 = B, 3 = broadcast to all three.
- `cmd_target`  in  8  target level.
- `cmd_step`  in  8  per-step increment; 0 means snap immediately.
- `level_out`  out  24  registered levels: [7:0] R, [15:8] G, [23:16] B; drives `pwm.level`.
- `busy`  out  3  per-channel ramp in progress.
- `done`  out  3  one-cycle pulse per channel when its level reaches the target.
- `frame_tick`  out  1  high while the frame counter equals 255.

## Operation
- **Frame counter.** 8-bit, free-running 0..255, wraps to 0. It stays phase-aligned with `pwm.count` when both leave reset on the same edge.
- **Prescaler.**
  - Counts frame ticks modulo `FRAME_DIV`.
  - A step strobe fires on the tick that completes the `FRAME_DIV`-th frame. With `FRAME_DIV`=1, every tick is a strobe.
- **Per-channel state.** Registers `level`, `target`, `step`, and FSM state IDLE or RAMP.
- **Command accept.**
  - A command is accepted when `cmd_valid && cmd_ready`.
  - `cmd_ready` is 1 in every cycle after reset release; there is no backpressure.
  - Broadcast writes the same `target`/`step` to all three channels.
- **On accept, per addressed channel:**
  - `cmd_step`==0 or `cmd_target`==`level`: `level` <= `target`, state -> IDLE, `done` pulses in the next cycle.
  - Otherwise: latch `target` and `step`, state -> RAMP, `busy` set.
  - A command to a channel already in RAMP retargets it. The ramp continues from the current `level`; no restart.
- **RAMP, on step strobe.**
  - Up: `level` <= min(`level`+`step`, `target`), computed 9-bit, no wrap.
  - Down: `level` <= max(`level`-`step`, `target`), computed 9-bit, no underflow.
  - When the new `level` equals `target`: state -> IDLE, `busy` clears and `done` pulses in the same cycle `level` updates.
- **Accept and strobe in the same cycle, same channel:** the command wins and that channel skips this strobe. Other channels step normally.
- **Reset mid-ramp:** everything clears immediately (asynchronous); ramps are abandoned.

## Timing
- Reset values:
  - `level_out`=0, `busy`=0, `done`=0, `cmd_ready`=0, `frame_tick`=0.
  - Frame counter=0, prescaler=0, all targets and steps 0, all FSMs IDLE.
- `cmd_ready` is registered and rises on the first clock edge after `reset` deasserts.
- Command to `level_out` and `busy`: 1 cycle latency.
- Strobe to `level_out`: the update occurs on the edge that ends the counter==255 cycle, coincident with the `pwm` counter wrapping to 0.
- `done` is exactly 1 cycle wide. It never pulses for a channel whose command is overwritten before reaching its target.
- `frame_tick` is decoded from the registered counter and is high for 1 of every 256 cycles.

## Configuration
- Macro `RGB_FADE_HOLD_EN`.
- **Defined:** adds input port `hold` (1 bit, active-high).
  - While `hold`=1, step strobes are ignored by all channels. `busy` is retained.
  - The frame counter and prescaler keep running.
  - Commands are still accepted, and snap commands still apply immediately.
- **Undefined:** no `hold` port; strobes are always honoured.

## Test plan
- Reset, then release -> all outputs 0; `cmd_ready`=1 one cycle later; `frame_tick` first high at counter 255, then every 256 cycles.
- `FRAME_DIV`=1: R command, target 0x40, step 0x10 -> R `level_out` steps to 0x10, 0x20, 0x30, 0x40 on 4 successive strobes; `done[0]` pulses with the 0x40 update; `busy[0]` clears in the same cycle.
- Down ramp with clamp: G at 0x30, command target 0x05, step 0x10 -> levels 0x20, 0x10, then 0x05, with no underflow. B ramp 0xF0 -> 0xFF with step 0x20 -> 0xFF on the first strobe, with no wrap.
- Broadcast snap: `cmd_chan`=3, target 0x80, step 0 -> all levels 0x80 one cycle later; `done`=3'b111 for 1 cycle.
- Collision and retarget:
  - A command issued in the counter==255 cycle on a ramping channel takes effect and that channel skips the step.
  - A retarget mid-ramp continues from the current level to the new target with no `done` for the old target.
- Reset asserted mid-ramp at an arbitrary cycle -> all outputs 0 immediately. With `RGB_FADE_HOLD_EN`: `hold`=1 freezes the level across 3 strobes, and the ramp resumes on the first strobe after release.
